// File: rtl/glb_store_dma_packer_pkg.sv
// Shared GLB constants and types for the store-direction DMA packer.
package global_buffer_param;

  localparam int GLB_ADDR_WIDTH      = 19;
  localparam int BANK_DATA_WIDTH     = 64;
  localparam int CGRA_DATA_WIDTH     = 16;
  localparam int MAX_NUM_WORDS_WIDTH = 16;

  // Stream handshake modes for the store DMA.
  localparam logic [1:0] ST_DMA_VALID_MODE_VALID       = 2'd0;
  localparam logic [1:0] ST_DMA_VALID_MODE_READY_VALID = 2'd1;
  localparam logic [1:0] ST_DMA_VALID_MODE_STATIC      = 2'd2;

  // CGRA words packed into one bank word.
  localparam int ST_DMA_NUM_LANES = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } st_dma_state_e;

endpackage

// File: rtl/glb_store_dma_packer_lane_merge.sv
// Combinational lane insert: drops one CGRA word into its lane of the
// packing register and ORs the matching byte strobes in.
module glb_st_lane_merge #(
  parameter int CGRA_DATA_WIDTH = global_buffer_param::CGRA_DATA_WIDTH,
  parameter int BANK_DATA_WIDTH = global_buffer_param::BANK_DATA_WIDTH,
  localparam int NUM_LANES      = BANK_DATA_WIDTH / CGRA_DATA_WIDTH,
  localparam int LANE_W         = $clog2(NUM_LANES),
  localparam int STRB_W         = BANK_DATA_WIDTH / 8,
  localparam int WORD_BYTES     = CGRA_DATA_WIDTH / 8
) (
  input  logic [BANK_DATA_WIDTH-1:0] pack_data,
  input  logic [STRB_W-1:0]          pack_strb,
  input  logic [CGRA_DATA_WIDTH-1:0] word,
  input  logic [LANE_W-1:0]          lane,
  output logic [BANK_DATA_WIDTH-1:0] merged_data,
  output logic [STRB_W-1:0]          merged_strb
);
  import global_buffer_param::*;

  // Overwrite the selected lane, keep every other lane as packed so far.
  always_comb begin
    merged_data = pack_data;
    merged_strb = pack_strb;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane == LANE_W'(i)) begin
        merged_data[i*CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH] = word;
        merged_strb[i*WORD_BYTES +: WORD_BYTES]           = {WORD_BYTES{1'b1}};
      end
    end
  end

endmodule

// File: rtl/glb_store_dma_packer.sv
// Store DMA for one GLB tile: packs the 16-bit CGRA store stream into
// 64-bit bank words with byte strobes and issues linear-address writes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a start pulse
// ST_RUN   | accepting stream words and packing them into bank words
// ST_DRAIN | all words accepted, waiting for the final write handshake
// ST_DONE  | one-cycle completion pulse, then back to idle
module glb_store_dma_packer #(
  parameter int GLB_ADDR_WIDTH      = global_buffer_param::GLB_ADDR_WIDTH,
  parameter int BANK_DATA_WIDTH     = global_buffer_param::BANK_DATA_WIDTH,
  parameter int CGRA_DATA_WIDTH     = global_buffer_param::CGRA_DATA_WIDTH,
  parameter int MAX_NUM_WORDS_WIDTH = global_buffer_param::MAX_NUM_WORDS_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [GLB_ADDR_WIDTH-1:0]      cfg_st_dma_start_addr,
  input  logic [MAX_NUM_WORDS_WIDTH-1:0] cfg_st_dma_num_words,
  input  logic [1:0]                     cfg_st_dma_valid_mode,
  input  logic                           st_dma_start_pulse,
  input  logic [CGRA_DATA_WIDTH-1:0]     strm_data_in,
  input  logic                           strm_data_valid_in,
  output logic                           strm_data_ready_out,
  output logic                           wr_en,
  input  logic                           wr_ready,
  output logic [GLB_ADDR_WIDTH-1:0]      wr_addr,
  output logic [BANK_DATA_WIDTH-1:0]     wr_data,
  output logic [BANK_DATA_WIDTH/8-1:0]   wr_strb,
  output logic                           st_dma_done_pulse,
  output logic                           st_dma_err_overflow
);
  import global_buffer_param::*;

  localparam int NUM_LANES  = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
  localparam int LANE_W     = $clog2(NUM_LANES);
  localparam int STRB_W     = BANK_DATA_WIDTH / 8;
  localparam int WORD_OFS_W = $clog2(STRB_W);
  localparam int WORD_BYTES = CGRA_DATA_WIDTH / 8;

  st_dma_state_e                  state_q, state_d;
  logic [GLB_ADDR_WIDTH-1:0]      cur_addr_q;
  logic [MAX_NUM_WORDS_WIDTH-1:0] words_left_q;
  logic [1:0]                     mode_q;
  logic [BANK_DATA_WIDTH-1:0]     pack_data_q;
  logic [STRB_W-1:0]              pack_strb_q;
  logic                           wr_en_q;
  logic [GLB_ADDR_WIDTH-1:0]      wr_addr_q;
  logic [BANK_DATA_WIDTH-1:0]     wr_data_q;
  logic [STRB_W-1:0]              wr_strb_q;
  logic                           err_q;

  logic                           start_idle;
  logic                           offered;
  logic                           can_accept;
  logic                           accept;
  logic                           drop;
  logic                           is_last;
  logic                           emit;
  logic                           wr_fire;
  logic [LANE_W-1:0]              lane;
  logic [BANK_DATA_WIDTH-1:0]     merged_data;
  logic [STRB_W-1:0]              merged_strb;

  assign start_idle = (state_q == ST_IDLE) && st_dma_start_pulse;
  assign wr_fire    = wr_en_q && wr_ready;

  // STATIC mode treats the stream as always valid.
  assign offered    = (state_q == ST_RUN) &&
                      ((mode_q == ST_DMA_VALID_MODE_STATIC) || strm_data_valid_in);
  // The output register is free when empty or being handed off this cycle.
  assign can_accept = (state_q == ST_RUN) && !(wr_en_q && !wr_ready);
  assign accept     = offered && can_accept;
  // Only READY_VALID sources hold a refused word; elsewhere it is lost.
  assign drop       = offered && !can_accept && (mode_q != ST_DMA_VALID_MODE_READY_VALID);

  assign lane    = cur_addr_q[WORD_OFS_W-1 -: LANE_W];
  assign is_last = (words_left_q == MAX_NUM_WORDS_WIDTH'(1));
  assign emit    = accept && ((lane == {LANE_W{1'b1}}) || is_last);

  glb_st_lane_merge #(
    .CGRA_DATA_WIDTH (CGRA_DATA_WIDTH),
    .BANK_DATA_WIDTH (BANK_DATA_WIDTH)
  ) u_lane_merge (
    .pack_data   (pack_data_q),
    .pack_strb   (pack_strb_q),
    .word        (strm_data_in),
    .lane        (lane),
    .merged_data (merged_data),
    .merged_strb (merged_strb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; starts outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (st_dma_start_pulse) begin
          if (cfg_st_dma_num_words == '0) state_d = ST_DONE;
          else                            state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && is_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wr_fire) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transfer address and remaining-word down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_q   <= '0;
      words_left_q <= '0;
      mode_q       <= ST_DMA_VALID_MODE_VALID;
    end else if (start_idle) begin
      cur_addr_q   <= cfg_st_dma_start_addr & ~GLB_ADDR_WIDTH'(1);
      words_left_q <= cfg_st_dma_num_words;
      mode_q       <= cfg_st_dma_valid_mode;
    end else if (accept) begin
      cur_addr_q   <= cur_addr_q + GLB_ADDR_WIDTH'(WORD_BYTES);
      words_left_q <= words_left_q - MAX_NUM_WORDS_WIDTH'(1);
    end
  end

  // Packing register: accumulate lanes, empty on every emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_data_q <= '0;
      pack_strb_q <= '0;
    end else if (start_idle || emit) begin
      pack_data_q <= '0;
      pack_strb_q <= '0;
    end else if (accept) begin
      pack_data_q <= merged_data;
      pack_strb_q <= merged_strb;
    end
  end

  // Write request register: load on emit, hold while stalled, drop after handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else if (emit) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= {cur_addr_q[GLB_ADDR_WIDTH-1:WORD_OFS_W], {WORD_OFS_W{1'b0}}};
      wr_data_q <= merged_data;
      wr_strb_q <= merged_strb;
    end else if (wr_fire) begin
      wr_en_q   <= 1'b0;
    end
  end

  // Sticky overflow flag, cleared by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start_idle) begin
      err_q <= 1'b0;
    end else if (drop) begin
      err_q <= 1'b1;
    end
  end

  assign strm_data_ready_out = can_accept;
  assign wr_en               = wr_en_q;
  assign wr_addr             = wr_addr_q;
  assign wr_data             = wr_data_q;
  assign wr_strb             = wr_strb_q;
  assign st_dma_done_pulse   = (state_q == ST_DONE);
  assign st_dma_err_overflow = err_q;

endmodule

// File: tb/tb_glb_store_dma_packer.sv
// Directed bench for glb_store_dma_packer: aligned/unaligned packing,
// backpressure, drop handling, empty transfers, STATIC mode and reset.
module tb_glb_store_dma_packer;
  import global_buffer_param::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] cfg_st_dma_start_addr;
  logic [15:0] cfg_st_dma_num_words;
  logic [1:0]  cfg_st_dma_valid_mode;
  logic        st_dma_start_pulse;
  logic [15:0] strm_data_in;
  logic        strm_data_valid_in;
  logic        strm_data_ready_out;
  logic        wr_en;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        st_dma_done_pulse;
  logic        st_dma_err_overflow;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int start_cyc = 0;

  logic [18:0] wq_addr[$];
  logic [63:0] wq_data[$];
  logic [7:0]  wq_strb[$];
  int          w_cyc[$];

  glb_store_dma_packer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cfg_st_dma_start_addr (cfg_st_dma_start_addr),
    .cfg_st_dma_num_words  (cfg_st_dma_num_words),
    .cfg_st_dma_valid_mode (cfg_st_dma_valid_mode),
    .st_dma_start_pulse    (st_dma_start_pulse),
    .strm_data_in          (strm_data_in),
    .strm_data_valid_in    (strm_data_valid_in),
    .strm_data_ready_out   (strm_data_ready_out),
    .wr_en                 (wr_en),
    .wr_ready              (wr_ready),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .wr_strb               (wr_strb),
    .st_dma_done_pulse     (st_dma_done_pulse),
    .st_dma_err_overflow   (st_dma_err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log write handshakes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (rst_n && wr_en && wr_ready) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_strb.push_back(wr_strb);
      w_cyc.push_back(cyc);
    end
    if (rst_n && st_dma_done_pulse) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [18:0] a,
                        input logic [63:0] d, input logic [7:0] s);
    if (idx < wq_addr.size()) begin
      chk({tag, "_addr"}, 64'(wq_addr[idx]), 64'(a));
      chk({tag, "_data"}, wq_data[idx], d);
      chk({tag, "_strb"}, 64'(wq_strb[idx]), 64'(s));
    end else begin
      chk({tag, "_present"}, 64'(0), 64'(1));
    end
  endtask

  task automatic clr_log();
    wq_addr.delete();
    wq_data.delete();
    wq_strb.delete();
    w_cyc.delete();
  endtask

  // Pulse start for one cycle; returns in the first cycle after the pulse.
  task automatic start_dma(input logic [18:0] a, input logic [15:0] n, input logic [1:0] m);
    @(posedge clk); #1;
    cfg_st_dma_start_addr = a;
    cfg_st_dma_num_words  = n;
    cfg_st_dma_valid_mode = m;
    st_dma_start_pulse    = 1'b1;
    start_cyc             = cyc;
    @(posedge clk); #1;
    st_dma_start_pulse    = 1'b0;
  endtask

  // READY_VALID source; optionally fires a stray start while word 'poke' is offered.
  task automatic feed_rv(input logic [15:0] base, input int n, input int poke);
    for (int i = 0; i < n; i++) begin
      int t;
      bit got;
      t = 0;
      got = 1'b0;
      strm_data_in       = base + 16'(i);
      strm_data_valid_in = 1'b1;
      if (i == poke) begin
        st_dma_start_pulse    = 1'b1;
        cfg_st_dma_start_addr = 19'h200;
        cfg_st_dma_num_words  = 16'd0;
      end
      while (!got && t < 50) begin
        @(negedge clk);
        got = strm_data_ready_out;
        @(posedge clk); #1;
        st_dma_start_pulse = 1'b0;
        t++;
      end
      if (!got) chk("feed_timeout", 64'(0), 64'(1));
    end
    strm_data_valid_in = 1'b0;
  endtask

  // Free-running source: a new word every cycle, no regard for ready.
  task automatic feed_cycles(input logic [15:0] base, input int n, input logic vld);
    for (int i = 0; i < n; i++) begin
      strm_data_in       = base + 16'(i);
      strm_data_valid_in = vld;
      @(posedge clk); #1;
    end
    strm_data_valid_in = 1'b0;
  endtask

  // Hold wr_ready low for the first 5 cycles of the first write request.
  task automatic stall_5(input string tag);
    int t;
    bit stable;
    bit rdy_low;
    logic [18:0] sa;
    logic [63:0] sd;
    logic [7:0]  ss;
    t = 0;
    stable = 1'b1;
    rdy_low = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!wr_en && t < 50);
    chk({tag, "_stall_seen"}, 64'(wr_en), 64'(1));
    sa = wr_addr;
    sd = wr_data;
    ss = wr_strb;
    if (strm_data_ready_out) rdy_low = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (!wr_en || wr_addr !== sa || wr_data !== sd || wr_strb !== ss) stable = 1'b0;
      if (strm_data_ready_out) rdy_low = 1'b0;
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    chk({tag, "_hold_stable"}, 64'(stable), 64'(1));
    chk({tag, "_ready_low"}, 64'(rdy_low), 64'(1));
  endtask

  task automatic wait_done(input string tag, input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt >= target), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    bit ok;
    rst_n                 = 1'b0;
    cfg_st_dma_start_addr = '0;
    cfg_st_dma_num_words  = '0;
    cfg_st_dma_valid_mode = '0;
    st_dma_start_pulse    = 1'b0;
    strm_data_in          = '0;
    strm_data_valid_in    = 1'b0;
    wr_ready              = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({wr_en, strm_data_ready_out, st_dma_done_pulse, st_dma_err_overflow}), 64'(0));
    chk("rst_addr", 64'(wr_addr), 64'(0));
    chk("rst_data", wr_data, 64'(0));
    chk("rst_strb", 64'(wr_strb), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: aligned READY_VALID, with a stray start mid-run
    clr_log();
    d0 = done_cnt;
    start_dma(19'h100, 16'd8, ST_DMA_VALID_MODE_READY_VALID);
    feed_rv(16'd1, 8, 2);
    wait_done("t1", d0 + 1);
    repeat (4) @(negedge clk);
    chk("t1_done_once", 64'(done_cnt - d0), 64'(1));
    chk("t1_nwr", 64'(wq_addr.size()), 64'(2));
    chk_wr("t1_w0", 0, 19'h100, 64'h0004_0003_0002_0001, 8'hFF);
    chk_wr("t1_w1", 1, 19'h108, 64'h0008_0007_0006_0005, 8'hFF);
    if (w_cyc.size() == 2) begin
      chk("t1_wr0_lat", 64'(w_cyc[0]), 64'(start_cyc + 5));
      chk("t1_wr1_lat", 64'(w_cyc[1]), 64'(start_cyc + 9));
      chk("t1_done_lat", 64'(last_done_cyc), 64'(w_cyc[1] + 1));
    end else begin
      chk("t1_wcyc_count", 64'(w_cyc.size()), 64'(2));
    end

    // 2: unaligned start spanning two bank words
    clr_log();
    d0 = done_cnt;
    start_dma(19'h10C, 16'd3, ST_DMA_VALID_MODE_READY_VALID);
    feed_rv(16'h21, 3, -1);
    wait_done("t2", d0 + 1);
    chk("t2_nwr", 64'(wq_addr.size()), 64'(2));
    chk_wr("t2_w0", 0, 19'h108, 64'h0022_0021_0000_0000, 8'hF0);
    chk_wr("t2_w1", 1, 19'h110, 64'h0000_0000_0000_0023, 8'h03);

    // 2b: odd start address, bit0 ignored, lanes 1..3 of one word
    clr_log();
    d0 = done_cnt;
    start_dma(19'h10B, 16'd3, ST_DMA_VALID_MODE_READY_VALID);
    feed_rv(16'h31, 3, -1);
    wait_done("t2b", d0 + 1);
    chk("t2b_nwr", 64'(wq_addr.size()), 64'(1));
    chk_wr("t2b_w0", 0, 19'h108, 64'h0033_0032_0031_0000, 8'hFC);

    // 3: READY_VALID with a 5-cycle stall on the first write
    clr_log();
    d0 = done_cnt;
    wr_ready = 1'b0;
    start_dma(19'h100, 16'd8, ST_DMA_VALID_MODE_READY_VALID);
    fork
      feed_rv(16'd1, 8, -1);
      stall_5("t3");
    join
    wait_done("t3", d0 + 1);
    chk("t3_nwr", 64'(wq_addr.size()), 64'(2));
    chk_wr("t3_w0", 0, 19'h100, 64'h0004_0003_0002_0001, 8'hFF);
    chk_wr("t3_w1", 1, 19'h108, 64'h0008_0007_0006_0005, 8'hFF);
    chk("t3_no_err", 64'(st_dma_err_overflow), 64'(0));

    // 4: VALID mode with the same stall; words 5..9 are dropped
    clr_log();
    d0 = done_cnt;
    wr_ready = 1'b0;
    start_dma(19'h100, 16'd8, ST_DMA_VALID_MODE_VALID);
    fork
      feed_cycles(16'd1, 13, 1'b1);
      stall_5("t4");
    join
    wait_done("t4", d0 + 1);
    @(negedge clk);
    chk("t4_err", 64'(st_dma_err_overflow), 64'(1));
    chk("t4_nwr", 64'(wq_addr.size()), 64'(2));
    chk_wr("t4_w0", 0, 19'h100, 64'h0004_0003_0002_0001, 8'hFF);
    chk_wr("t4_w1", 1, 19'h108, 64'h000D_000C_000B_000A, 8'hFF);

    // 5: zero-length start clears the flag and finishes without writes
    clr_log();
    d0 = done_cnt;
    start_dma(19'h300, 16'd0, ST_DMA_VALID_MODE_VALID);
    @(negedge clk);
    chk("t5_err_clr", 64'(st_dma_err_overflow), 64'(0));
    wait_done("t5", d0 + 1);
    chk("t5_done_lat", 64'(last_done_cyc), 64'(start_cyc + 1));
    repeat (3) @(negedge clk);
    chk("t5_nwr", 64'(wq_addr.size()), 64'(0));
    chk("t5_done_once", 64'(done_cnt - d0), 64'(1));

    // 6: STATIC mode, valid held low, 5 back-to-back words
    clr_log();
    d0 = done_cnt;
    start_dma(19'h040, 16'd5, ST_DMA_VALID_MODE_STATIC);
    fork
      feed_cycles(16'h00A0, 5, 1'b0);
      begin
        bit rdy_ok;
        rdy_ok = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (!strm_data_ready_out) rdy_ok = 1'b0;
        end
        chk("t6_ready", 64'(rdy_ok), 64'(1));
      end
    join
    wait_done("t6", d0 + 1);
    chk("t6_nwr", 64'(wq_addr.size()), 64'(2));
    chk_wr("t6_w0", 0, 19'h040, 64'h00A3_00A2_00A1_00A0, 8'hFF);
    chk_wr("t6_w1", 1, 19'h048, 64'h0000_0000_0000_00A4, 8'h03);
    chk("t6_no_err", 64'(st_dma_err_overflow), 64'(0));

    // 7: reset while a write is pending in a STATIC run
    clr_log();
    d0 = done_cnt;
    wr_ready = 1'b0;
    start_dma(19'h080, 16'd100, ST_DMA_VALID_MODE_STATIC);
    repeat (5) @(negedge clk);
    chk("t7_pending", 64'(wr_en), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_rst_ctrl", 64'({wr_en, strm_data_ready_out, st_dma_done_pulse, st_dma_err_overflow}), 64'(0));
    chk("t7_rst_addr", 64'(wr_addr), 64'(0));
    chk("t7_rst_data", wr_data, 64'(0));
    chk("t7_rst_strb", 64'(wr_strb), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (strm_data_ready_out || wr_en || st_dma_done_pulse) ok = 1'b0;
    end
    chk("t7_idle_after", 64'(ok), 64'(1));
    chk("t7_nwr", 64'(wq_addr.size()), 64'(0));

    // Fresh single-word transfer after reset
    start_dma(19'h000, 16'd1, ST_DMA_VALID_MODE_READY_VALID);
    feed_rv(16'h0055, 1, -1);
    wait_done("t8", d0 + 1);
    chk("t8_nwr", 64'(wq_addr.size()), 64'(1));
    chk_wr("t8_w0", 0, 19'h000, 64'h0000_0000_0000_0055, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
